// File: rtl/gn_pkg.sv
// Shared definitions for the guess-number button front end.
// Holds the key codes, the arbiter state type and the priority-pick helpers.
package gn_pkg;

    localparam int NUM_KEYS = 5;

    localparam logic [2:0] KEY_NONE  = 3'd0;
    localparam logic [2:0] KEY_I1    = 3'd1;
    localparam logic [2:0] KEY_I2    = 3'd2;
    localparam logic [2:0] KEY_I3    = 3'd3;
    localparam logic [2:0] KEY_I4    = 3'd4;
    localparam logic [2:0] KEY_ENTER = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } arb_state_t;

    // Bit 0 (I1) is the highest priority; the descending loop lets it win.
    function automatic logic [NUM_KEYS-1:0] first_key(input logic [NUM_KEYS-1:0] lv);
        logic [NUM_KEYS-1:0] sel;
        sel = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (lv[i]) begin
                sel = NUM_KEYS'(1) << i;
            end
        end
        return sel;
    endfunction

    function automatic logic [2:0] code_of(input logic [NUM_KEYS-1:0] onehot);
        logic [2:0] code;
        case (onehot)
            5'b00001: code = KEY_I1;
            5'b00010: code = KEY_I2;
            5'b00100: code = KEY_I3;
            5'b01000: code = KEY_I4;
            5'b10000: code = KEY_ENTER;
            default:  code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/gn_debounce.sv
// One button channel: two-flop synchroniser followed by a counting debouncer.
// The stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module gn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_sync1,
    output logic o_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // Clearing on the flip keeps the counter below DEBOUNCE_CYCLES.
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sync1  = r_sync1;
    assign o_stable = r_stable;

endmodule

// File: rtl/gn_button_conditioner.sv
// Button front end: five debounced channels feeding a one-key-at-a-time arbiter
// that emits a single registered pulse per accepted press.
module gn_button_conditioner
    import gn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_I1,
    input  logic       btn_I2,
    input  logic       btn_I3,
    input  logic       btn_I4,
    input  logic       btn_enter,
    output logic       I1,
    output logic       I2,
    output logic       I3,
    output logic       I4,
    output logic       enter,
    output logic       key_valid,
    output logic [2:0] key_code,
    output logic       busy
);

    localparam int SET_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(DEBOUNCE_CYCLES + 1);

    logic [NUM_KEYS-1:0] w_btn_raw;
    logic [NUM_KEYS-1:0] w_sync1;
    logic [NUM_KEYS-1:0] w_stable;
    logic                w_any_stable;
    logic                w_any_sync1;

    arb_state_t          r_state;
    logic [NUM_KEYS-1:0] r_pulse;
    logic [2:0]          r_key_code;
    logic                r_key_valid;
    logic [SET_W-1:0]    r_settle;

    assign w_btn_raw = {btn_enter, btn_I4, btn_I3, btn_I2, btn_I1};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        gn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clk   (clk),
            .i_reset (reset),
            .i_btn   (w_btn_raw[g]),
            .o_sync1 (w_sync1[g]),
            .o_stable(w_stable[g])
        );
    end

    assign w_any_stable = |w_stable;
    assign w_any_sync1  = |w_sync1;

    // Reset clears the stable levels, so a key held through reset would look released.
    // Leaving HELD therefore also needs one quiet window after reset; once seen it latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle <= '0;
        end else if (r_settle != SET_MAX) begin
            r_settle <= w_any_sync1 ? '0 : r_settle + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HELD;
            r_pulse     <= '0;
            r_key_code  <= KEY_NONE;
            r_key_valid <= 1'b0;
        end else begin
            r_pulse     <= '0;
            r_key_code  <= KEY_NONE;
            r_key_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_stable) begin
                        r_pulse     <= first_key(w_stable);
                        r_key_code  <= code_of(first_key(w_stable));
                        r_key_valid <= 1'b1;
                        r_state     <= HELD;
                    end
                end
                HELD: begin
                    if (!w_any_stable && (r_settle == SET_MAX)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= HELD;
            endcase
        end
    end

    assign I1        = r_pulse[0];
    assign I2        = r_pulse[1];
    assign I3        = r_pulse[2];
    assign I4        = r_pulse[3];
    assign enter     = r_pulse[4];
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign busy      = (r_state == HELD);

endmodule
